// File: rtl/fe_pkg.sv
// Shared types and defaults for the feature-extractor sample scheduler.
// Frame geometry defaults plus the widths of the frame index/count outputs.
package fe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } sched_state_t;

    localparam int FRAME_LEN_DEF = 512;
    localparam int HOP_LEN_DEF   = 256;
    localparam int FRAME_IDX_W   = 8;
    localparam int FRAME_CNT_W   = 16;

endpackage

// File: rtl/fe_sample_sched_if.sv
// Sample/frame bus between the audio front end, the scheduler and the FFT stage.
// master = environment side (drives samples/acks), slave = scheduler side.
interface fe_sample_sched_if
    import fe_pkg::*;
#(
    parameter int DATA_WIDTH = 12
) ();

    logic                          sample_vld;
    logic signed [DATA_WIDTH-1:0]  audio_in;
    logic                          spi_en_inf_sample_sync;
    logic                          spi_en_fe_sample_sync;
    logic                          buf_full;
    logic                          frame_ack;
    logic signed [DATA_WIDTH-1:0]  audio_out;
    logic                          emp_clr;
    logic                          w_req;
    logic                          frame_rdy;
    logic [FRAME_IDX_W-1:0]        frame_idx;
    logic                          ovf_err;
    logic [FRAME_CNT_W-1:0]        frame_cnt;

    modport master (
        output sample_vld, audio_in, spi_en_inf_sample_sync, spi_en_fe_sample_sync,
               buf_full, frame_ack,
        input  audio_out, emp_clr, w_req, frame_rdy, frame_idx, ovf_err, frame_cnt
    );

    modport slave (
        input  sample_vld, audio_in, spi_en_inf_sample_sync, spi_en_fe_sample_sync,
               buf_full, frame_ack,
        output audio_out, emp_clr, w_req, frame_rdy, frame_idx, ovf_err, frame_cnt
    );

endinterface

// File: rtl/fe_samp_cnt.sv
// Accepted-sample counter with a runtime terminal value; done pulses combinationally
// on the increment that reaches the terminal, and the count wraps to zero there.
module fe_samp_cnt #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = cnt_q + CNT_W'(1);
    assign done_o  = inc_i & ~clr_i & (cnt_nxt == term_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = done_o ? '0 : cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fe_sample_sched.sv
// Gates audio samples into the pre-emphasis/frame buffer (1-cycle latency, drops on buf_full)
// and raises frame_rdy every FRAME_LEN then HOP_LEN samples; FE_FRAME_CNT_EN builds frame_cnt.
module fe_sample_sched
    import fe_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int FRAME_LEN  = FRAME_LEN_DEF,
    parameter int HOP_LEN    = HOP_LEN_DEF,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    fe_sample_sched_if.slave   bus
);

    sched_state_t                 state_q, state_d;
    logic signed [DATA_WIDTH-1:0] audio_out_q, audio_out_d;
    logic                         emp_clr_q, emp_clr_d;
    logic                         w_req_q, w_req_d;
    logic                         frame_rdy_q, frame_rdy_d;
    logic [FRAME_IDX_W-1:0]       frame_idx_q, frame_idx_d;
    logic                         ovf_err_q, ovf_err_d;

    logic             ena;
    logic             accept;
    logic             drop;
    logic             frame_evt;
    logic [CNT_W-1:0] term;

    assign ena    = bus.spi_en_inf_sample_sync & bus.spi_en_fe_sample_sync;
    // The IDLE->PRIME cycle already accepts, so state is not part of the gate.
    assign accept = bus.sample_vld & ena & ~bus.buf_full;
    assign drop   = bus.sample_vld & ena & bus.buf_full;
    assign term   = (state_q == RUN) ? CNT_W'(HOP_LEN) : CNT_W'(FRAME_LEN);

    fe_samp_cnt #(
        .CNT_W (CNT_W)
    ) u_samp_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (~ena),
        .inc_i  (accept),
        .term_i (term),
        .done_o (frame_evt)
    );

    always_comb begin
        state_d     = state_q;
        audio_out_d = audio_out_q;
        emp_clr_d   = 1'b0;
        w_req_d     = accept;
        frame_rdy_d = frame_rdy_q;
        frame_idx_d = frame_idx_q + FRAME_IDX_W'(frame_evt);
        ovf_err_d   = ovf_err_q | drop | (frame_evt & frame_rdy_q & ~bus.frame_ack);

        if (accept) begin
            audio_out_d = bus.audio_in;
        end

        if (!ena) begin
            state_d     = IDLE;
            frame_rdy_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    emp_clr_d = 1'b1;
                    state_d   = frame_evt ? RUN : PRIME;
                end
                PRIME:   state_d = frame_evt ? RUN : PRIME;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase

            // A new frame outranks an ack landing in the same cycle.
            if (frame_evt) begin
                frame_rdy_d = 1'b1;
            end else if (bus.frame_ack) begin
                frame_rdy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            audio_out_q <= '0;
            emp_clr_q   <= 1'b0;
            w_req_q     <= 1'b0;
            frame_rdy_q <= 1'b0;
            frame_idx_q <= '0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            audio_out_q <= audio_out_d;
            emp_clr_q   <= emp_clr_d;
            w_req_q     <= w_req_d;
            frame_rdy_q <= frame_rdy_d;
            frame_idx_q <= frame_idx_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

`ifdef FE_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_evt && (frame_cnt_q != {FRAME_CNT_W{1'b1}})) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
`else
    assign bus.frame_cnt = '0;
`endif

    assign bus.audio_out = audio_out_q;
    assign bus.emp_clr   = emp_clr_q;
    assign bus.w_req     = w_req_q;
    assign bus.frame_rdy = frame_rdy_q;
    assign bus.frame_idx = frame_idx_q;
    assign bus.ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_fe_sample_sched.sv
// Directed bench for fe_sample_sched with FRAME_LEN=8, HOP_LEN=4.
module tb_fe_sample_sched;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    fe_sample_sched_if #(.DATA_WIDTH(12)) bus ();

    fe_sample_sched #(
        .DATA_WIDTH (12),
        .FRAME_LEN  (8),
        .HOP_LEN    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt_model();
`ifdef FE_FRAME_CNT_EN
        return exp_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input int v);
        bus.sample_vld = 1'b1;
        bus.audio_in   = 12'(v);
        tick();
        bus.sample_vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.sample_vld = 1'b0;
        bus.audio_in = '0;
        bus.spi_en_inf_sample_sync = 1'b0;
        bus.spi_en_fe_sample_sync = 1'b0;
        bus.buf_full = 1'b0;
        bus.frame_ack = 1'b0;
        tick();
        tick();
        chk("rst_audio_out", 32'(bus.audio_out), 0);
        chk("rst_emp_clr", 32'(bus.emp_clr), 0);
        chk("rst_w_req", 32'(bus.w_req), 0);
        chk("rst_frame_rdy", 32'(bus.frame_rdy), 0);
        chk("rst_frame_idx", 32'(bus.frame_idx), 0);
        chk("rst_ovf_err", 32'(bus.ovf_err), 0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 0);
        rst_n = 1'b1;
        tick();

        // First frame: 8 samples from IDLE.
        bus.spi_en_inf_sample_sync = 1'b1;
        bus.spi_en_fe_sample_sync = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            smp(i);
            chk("a_w_req", 32'(bus.w_req), 1);
            chk("a_audio_out", 32'(bus.audio_out), 32'(i));
            chk("a_emp_clr", 32'(bus.emp_clr), 32'(i == 1));
            chk("a_frame_rdy", 32'(bus.frame_rdy), 32'(i == 8));
        end
        exp_cnt++;
        chk("a_frame_idx", 32'(bus.frame_idx), 1);
        chk("a_ovf_err", 32'(bus.ovf_err), 0);
        chk("a_frame_cnt", 32'(bus.frame_cnt), 32'(cnt_model()));

        // Ack, then one hop.
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        chk("b_rdy_after_ack", 32'(bus.frame_rdy), 0);
        chk("b_w_req_idle", 32'(bus.w_req), 0);
        chk("b_emp_clr_once", 32'(bus.emp_clr), 0);
        for (int i = 9; i <= 12; i++) begin
            smp(i);
            chk("b_audio_out", 32'(bus.audio_out), 32'(i));
            chk("b_frame_rdy", 32'(bus.frame_rdy), 32'(i == 12));
        end
        exp_cnt++;
        chk("b_frame_idx", 32'(bus.frame_idx), 2);
        chk("b_ovf_err", 32'(bus.ovf_err), 0);

        // Ack coinciding with the next frame event.
        for (int i = 13; i <= 15; i++) begin
            smp(i);
            chk("c_rdy_held", 32'(bus.frame_rdy), 1);
        end
        bus.frame_ack = 1'b1;
        smp(16);
        bus.frame_ack = 1'b0;
        exp_cnt++;
        chk("c_frame_rdy", 32'(bus.frame_rdy), 1);
        chk("c_ovf_err", 32'(bus.ovf_err), 0);
        chk("c_frame_idx", 32'(bus.frame_idx), 3);

        // Frame event with no ack: overrun.
        for (int i = 17; i <= 20; i++) smp(i);
        exp_cnt++;
        chk("d_ovf_err", 32'(bus.ovf_err), 1);
        chk("d_frame_rdy", 32'(bus.frame_rdy), 1);
        chk("d_frame_idx", 32'(bus.frame_idx), 4);
        chk("d_frame_cnt", 32'(bus.frame_cnt), 32'(cnt_model()));

        // Reset clears sticky state.
        rst_n = 1'b0;
        bus.spi_en_inf_sample_sync = 1'b0;
        bus.spi_en_fe_sample_sync = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        chk("e_rst_idx", 32'(bus.frame_idx), 0);
        chk("e_rst_ovf", 32'(bus.ovf_err), 0);
        chk("e_rst_cnt", 32'(bus.frame_cnt), 0);
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        chk("e_stray_ack", 32'(bus.frame_rdy), 0);

        bus.spi_en_inf_sample_sync = 1'b1;
        bus.spi_en_fe_sample_sync = 1'b1;
        for (int i = 1; i <= 8; i++) smp(i);
        exp_cnt++;
        chk("e_frame_rdy", 32'(bus.frame_rdy), 1);
        chk("e_frame_idx", 32'(bus.frame_idx), 1);
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;

        // Drops while the buffer is full.
        bus.buf_full = 1'b1;
        for (int i = 21; i <= 23; i++) begin
            smp(i);
            chk("e_drop_w_req", 32'(bus.w_req), 0);
            chk("e_drop_ovf", 32'(bus.ovf_err), 1);
        end
        bus.buf_full = 1'b0;
        tick();
        chk("e_ovf_sticky", 32'(bus.ovf_err), 1);
        chk("e_audio_held", 32'(bus.audio_out), 8);
        for (int i = 31; i <= 34; i++) begin
            smp(i);
            chk("e_hop_rdy", 32'(bus.frame_rdy), 32'(i == 34));
        end
        exp_cnt++;
        chk("e_hop_idx", 32'(bus.frame_idx), 2);
        chk("e_frame_cnt", 32'(bus.frame_cnt), 32'(cnt_model()));

        // Enable drop mid-PRIME restarts the window.
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        bus.spi_en_fe_sample_sync = 1'b0;
        tick();
        bus.spi_en_fe_sample_sync = 1'b1;
        for (int i = 41; i <= 45; i++) begin
            smp(i);
            chk("f_emp_clr", 32'(bus.emp_clr), 32'(i == 41));
        end
        bus.spi_en_fe_sample_sync = 1'b0;
        smp(46);
        chk("f_w_req_suppr", 32'(bus.w_req), 0);
        chk("f_audio_held", 32'(bus.audio_out), 45);
        chk("f_rdy_off", 32'(bus.frame_rdy), 0);
        chk("f_idx_kept", 32'(bus.frame_idx), 2);
        bus.spi_en_fe_sample_sync = 1'b1;
        for (int i = 51; i <= 58; i++) begin
            smp(i);
            chk("f_emp_clr2", 32'(bus.emp_clr), 32'(i == 51));
            chk("f_frame_rdy", 32'(bus.frame_rdy), 32'(i == 58));
        end
        exp_cnt++;
        chk("f_frame_idx", 32'(bus.frame_idx), 3);
        chk("f_ovf_err", 32'(bus.ovf_err), 1);
        chk("f_frame_cnt", 32'(bus.frame_cnt), 32'(cnt_model()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
